// File: rtl/sig_acc_mc.sv
// sig_acc_mc: multi-channel signed fixed-point accumulator with saturation and sticky overflow flags.
// Optional macro SIG_ACC_MC_ROUND_EN: round half toward +inf when the output has fewer fraction bits.
module sig_acc_mc #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_INT    = 4,
  parameter int DOUT_WIDTH = 32,
  parameter int DOUT_INT   = 14,
  parameter int NCH        = 4,
  parameter int CH_WIDTH   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  input  logic                         din_last,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic [CH_WIDTH-1:0]          dout_ch,
  output logic                         dout_valid,
  output logic                         dout_ovf
);
  // Stream protocol: valid-only, no backpressure. A sample is consumed on every
  // edge where din_valid=1; din_last is meaningful only then. dout_valid is a
  // one-cycle strobe and dout/dout_ch/dout_ovf hold until the next strobe.

  localparam int DIN_POINT  = DIN_WIDTH - DIN_INT;
  localparam int DOUT_POINT = DOUT_WIDTH - DOUT_INT;
  localparam int EXT_W      = ((DIN_WIDTH > DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH) + 2;
  localparam int SUM_W      = DOUT_WIDTH + 2;

  localparam logic signed [SUM_W-1:0] MAX_POS = {3'b000, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_NEG = {3'b111, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [DOUT_WIDTH-1:0] r_acc [NCH];
  logic [NCH-1:0]               r_flag;
  logic [CH_WIDTH-1:0]          r_ch;

  logic signed [EXT_W-1:0]      w_din_ext;
  logic signed [EXT_W-1:0]      w_shifted;
  logic signed [DOUT_WIDTH:0]   w_aligned;
  logic                         w_unused_ext;
  logic signed [DOUT_WIDTH-1:0] w_acc_rd;
  logic                         w_flag_rd;
  logic signed [SUM_W-1:0]      w_sum;
  logic signed [DOUT_WIDTH-1:0] w_sat;
  logic                         w_ovf_now;
  logic [CH_WIDTH-1:0]          w_ch_next;

  assign w_din_ext = {{(EXT_W-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};

  generate
    if (DOUT_POINT >= DIN_POINT) begin : g_left
      assign w_shifted = w_din_ext <<< (DOUT_POINT - DIN_POINT);
    end else begin : g_right
      localparam int SH = DIN_POINT - DOUT_POINT;
`ifdef SIG_ACC_MC_ROUND_EN
      localparam logic signed [EXT_W-1:0] HALF = {{(EXT_W-1){1'b0}}, 1'b1} << (SH - 1);
      assign w_shifted = (w_din_ext + HALF) >>> SH;
`else
      assign w_shifted = w_din_ext >>> SH;
`endif
    end
  endgenerate

  // Aligned value always fits in DOUT_WIDTH+1 bits (rounding may reach +2^(DOUT_WIDTH-1)).
  assign w_aligned    = w_shifted[DOUT_WIDTH:0];
  assign w_unused_ext = ^w_shifted[EXT_W-1:DOUT_WIDTH+1];

  assign w_acc_rd  = r_acc[r_ch];
  assign w_flag_rd = r_flag[r_ch];
  assign w_sum     = {{2{w_acc_rd[DOUT_WIDTH-1]}}, w_acc_rd} + {w_aligned[DOUT_WIDTH], w_aligned};

  always_comb begin
    w_ovf_now = 1'b0;
    w_sat     = w_sum[DOUT_WIDTH-1:0];
    if (w_sum > MAX_POS) begin
      w_sat     = MAX_POS[DOUT_WIDTH-1:0];
      w_ovf_now = 1'b1;
    end else if (w_sum < MIN_NEG) begin
      w_sat     = MIN_NEG[DOUT_WIDTH-1:0];
      w_ovf_now = 1'b1;
    end
  end

  assign w_ch_next = (r_ch == CH_WIDTH'(NCH - 1)) ? '0 : r_ch + CH_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      r_flag     <= '0;
      r_ch       <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      dout_ovf   <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      r_flag     <= '0;
      r_ch       <= '0;
      dout_valid <= 1'b0;
    end else if (din_valid) begin
      r_ch <= w_ch_next;
      if (din_last) begin
        // Emit and restart the frame on the same edge.
        r_acc[r_ch]  <= '0;
        r_flag[r_ch] <= 1'b0;
        dout         <= w_sat;
        dout_ch      <= r_ch;
        dout_ovf     <= w_flag_rd | w_ovf_now;
        dout_valid   <= 1'b1;
      end else begin
        r_acc[r_ch]  <= w_sat;
        r_flag[r_ch] <= w_flag_rd | w_ovf_now;
        dout_valid   <= 1'b0;
      end
    end else begin
      dout_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sig_acc_mc.sv
// tb_sig_acc_mc: five sig_acc_mc configurations on a shared input stream,
// checked against an arithmetic reference model plus hand-computed vectors.
module tb_sig_acc_mc;
  localparam int ND = 5;

`ifdef SIG_ACC_MC_ROUND_EN
  localparam longint R6_POS = 2;
  localparam longint R6_NEG = -1;
`else
  localparam longint R6_POS = 1;
  localparam longint R6_NEG = -2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic signed [15:0] din;
  logic din_valid;
  logic din_last;
  always #5 clk = ~clk;

  logic signed [31:0] dout_a; logic [0:0] ch_a; logic v_a, o_a;
  logic signed [15:0] dout_b; logic [1:0] ch_b; logic v_b, o_b;
  logic signed [15:0] dout_c; logic [0:0] ch_c; logic v_c, o_c;
  logic signed [15:0] dout_d; logic [0:0] ch_d; logic v_d, o_d;
  logic signed [7:0]  dout_e; logic [0:0] ch_e; logic v_e, o_e;

  sig_acc_mc #(.DIN_WIDTH(16), .DIN_INT(4), .DOUT_WIDTH(32), .DOUT_INT(14), .NCH(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid), .din_last(din_last),
    .dout(dout_a), .dout_ch(ch_a), .dout_valid(v_a), .dout_ovf(o_a));
  sig_acc_mc #(.DIN_WIDTH(16), .DIN_INT(4), .DOUT_WIDTH(16), .DOUT_INT(4), .NCH(4)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid), .din_last(din_last),
    .dout(dout_b), .dout_ch(ch_b), .dout_valid(v_b), .dout_ovf(o_b));
  sig_acc_mc #(.DIN_WIDTH(16), .DIN_INT(4), .DOUT_WIDTH(16), .DOUT_INT(4), .NCH(1)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid), .din_last(din_last),
    .dout(dout_c), .dout_ch(ch_c), .dout_valid(v_c), .dout_ovf(o_c));
  sig_acc_mc #(.DIN_WIDTH(16), .DIN_INT(4), .DOUT_WIDTH(16), .DOUT_INT(4), .NCH(2)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid), .din_last(din_last),
    .dout(dout_d), .dout_ch(ch_d), .dout_valid(v_d), .dout_ovf(o_d));
  sig_acc_mc #(.DIN_WIDTH(16), .DIN_INT(4), .DOUT_WIDTH(8), .DOUT_INT(4), .NCH(1)) u_e (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid), .din_last(din_last),
    .dout(dout_e), .dout_ch(ch_e), .dout_valid(v_e), .dout_ovf(o_e));

  longint g_dout [ND];
  int     g_ch   [ND];
  bit     g_vld  [ND];
  bit     g_ovf  [ND];
  always_comb begin
    g_dout[0] = longint'(dout_a); g_ch[0] = int'(ch_a); g_vld[0] = v_a; g_ovf[0] = o_a;
    g_dout[1] = longint'(dout_b); g_ch[1] = int'(ch_b); g_vld[1] = v_b; g_ovf[1] = o_b;
    g_dout[2] = longint'(dout_c); g_ch[2] = int'(ch_c); g_vld[2] = v_c; g_ovf[2] = o_c;
    g_dout[3] = longint'(dout_d); g_ch[3] = int'(ch_d); g_vld[3] = v_d; g_ovf[3] = o_d;
    g_dout[4] = longint'(dout_e); g_ch[4] = int'(ch_e); g_vld[4] = v_e; g_ovf[4] = o_e;
  end

  int cfg_nch [ND] = '{1, 4, 1, 2, 1};
  int cfg_ow  [ND] = '{32, 16, 16, 16, 8};
  int cfg_oi  [ND] = '{14, 4, 4, 4, 4};

  // reference model + scoreboard
  longint m_acc  [ND][4];
  bit     m_flag [ND][4];
  int     m_ch   [ND];
  bit     exp_vld   [ND];
  longint held_dout [ND];
  int     held_ch   [ND];
  bit     held_ovf  [ND];
  logic [67:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int d, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, d, $time, got, exp);
    end
  endtask

  // Input scaled to the output's fraction: exact scaling, then floor (or round half up).
  function automatic longint align(input int d, input logic signed [15:0] x);
    int  dp = 12;
    int  op = cfg_ow[d] - cfg_oi[d];
    real v;
    if (op >= dp) return longint'(x) * (longint'(1) <<< (op - dp));
    v = real'(x) / (2.0 ** (dp - op));
`ifdef SIG_ACC_MC_ROUND_EN
    v = v + 0.5;
`endif
    return longint'($floor(v));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < 4; c++) begin m_acc[d][c] = 0; m_flag[d][c] = 0; end
      m_ch[d] = 0; exp_vld[d] = 0; held_dout[d] = 0; held_ch[d] = 0; held_ovf[d] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input logic signed [15:0] x, input bit v, input bit last, input bit c);
    longint mx, mn, s;
    bit o;
    for (int d = 0; d < ND; d++) begin
      exp_vld[d] = 0;
      if (c) begin
        for (int k = 0; k < 4; k++) begin m_acc[d][k] = 0; m_flag[d][k] = 0; end
        m_ch[d] = 0;
      end else if (v) begin
        mx = (longint'(1) <<< (cfg_ow[d] - 1)) - 1;
        mn = -mx - 1;
        s  = m_acc[d][m_ch[d]] + align(d, x);
        o  = 0;
        if (s > mx) begin s = mx; o = 1; end
        else if (s < mn) begin s = mn; o = 1; end
        if (last) begin
          exp_q.push_back({m_flag[d][m_ch[d]] | o, 3'(m_ch[d]), 64'(s)});
          exp_vld[d] = 1;
          m_acc[d][m_ch[d]] = 0;
          m_flag[d][m_ch[d]] = 0;
        end else begin
          m_acc[d][m_ch[d]] = s;
          m_flag[d][m_ch[d]] = m_flag[d][m_ch[d]] | o;
        end
        m_ch[d] = (m_ch[d] + 1) % cfg_nch[d];
      end
    end
  endtask

  task automatic check_all();
    logic [67:0] e;
    for (int d = 0; d < ND; d++) begin
      chk("dout_valid", d, longint'(g_vld[d]), longint'(exp_vld[d]));
      if (exp_vld[d]) begin
        e = exp_q.pop_front();
        held_dout[d] = longint'(e[63:0]);
        held_ch[d]   = int'(e[66:64]);
        held_ovf[d]  = e[67];
      end
      chk("dout", d, g_dout[d], held_dout[d]);
      chk("dout_ch", d, longint'(g_ch[d]), longint'(held_ch[d]));
      chk("dout_ovf", d, longint'(g_ovf[d]), longint'(held_ovf[d]));
    end
  endtask

  // driver
  task automatic step(input logic signed [15:0] x, input bit v, input bit last, input bit c);
    din = x; din_valid = v; din_last = last; clr = c;
    model_step(x, v, last, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic signed [15:0] x;
    bit     v;
    bit     last;
    bit     c;
    int     d;
    bit     chk;
    longint e_dout;
    int     e_ch;
    bit     e_ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic signed [15:0] x, input bit v, input bit last, input bit c,
                     input int d, input bit ck, input longint e, input int ech, input bit eo);
    vec_t t;
    t.x = x; t.v = v; t.last = last; t.c = c; t.d = d; t.chk = ck;
    t.e_dout = e; t.e_ch = ech; t.e_ovf = eo;
    tbl.push_back(t);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic signed [15:0] t2_in [4];
    longint t2_exp [4];
    int d;
    t2_in  = '{16'sh0100, 16'sh0200, -16'sh0100, 16'sh0000};
    t2_exp = '{768, 1536, -768, 0};

    rst = 1'b0; clr = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b1;

    // 32/14 output, NCH=1: 4 x 1.0 then 2 x -1.0 back to back
    add(16'sh0000, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(16'sh1000, 1, 0, 0, 0, 0, 0, 0, 0);
    add(16'sh1000, 1, 1, 0, 0, 1, 64'sh100000, 0, 0);
    add(-16'sh1000, 1, 0, 0, 0, 0, 0, 0, 0);
    add(-16'sh1000, 1, 1, 0, 0, 1, -64'sh80000, 0, 0);
    // NCH=4 interleaved rounds, last on round 3
    add(16'sh0000, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        add(t2_in[k], 1, r == 2, 0, 1, r == 2, t2_exp[k], k, 0);
    // overflow, recovery, next frame clean, underflow
    add(16'sh0000, 0, 0, 1, 2, 0, 0, 0, 0);
    add(16'sh7000, 1, 0, 0, 2, 0, 0, 0, 0);
    add(16'sh7000, 1, 0, 0, 2, 0, 0, 0, 0);
    add(-16'sh7000, 1, 1, 0, 2, 1, 64'sh0FFF, 0, 1);
    add(16'sh0100, 1, 1, 0, 2, 1, 64'sh0100, 0, 0);
    add(-16'sh8000, 1, 0, 0, 2, 0, 0, 0, 0);
    add(-16'sh8000, 1, 1, 0, 2, 1, -64'sh8000, 0, 1);
    // NCH=2: gapless, gapped (ignored last on idle), clear mid-frame
    add(16'sh0000, 0, 0, 1, 3, 0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        add(16'sh0100, 1, k >= 2, 0, 3, k >= 2, 64'sh0200, k % 2, 0);
        if (g == 1) add(16'sh7777, 0, 1, 0, 3, 0, 0, 0, 0);
      end
    end
    add(16'sh0100, 1, 0, 0, 3, 0, 0, 0, 0);
    add(16'sh0100, 1, 0, 0, 3, 0, 0, 0, 0);
    add(16'sh0100, 1, 0, 0, 3, 0, 0, 0, 0);
    add(16'sh0000, 1, 0, 1, 3, 0, 0, 0, 0);
    add(16'sh0100, 1, 1, 0, 3, 1, 64'sh0100, 0, 0);
    add(16'sh0100, 1, 1, 0, 3, 1, 64'sh0100, 1, 0);
    // 16/4 -> 8/4 alignment: truncation or rounding
    add(16'sh0000, 0, 0, 1, 4, 0, 0, 0, 0);
    add(16'sh0180, 1, 1, 0, 4, 1, R6_POS, 0, 0);
    add(-16'sh0180, 1, 1, 0, 4, 1, R6_NEG, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].x, tbl[i].v, tbl[i].last, tbl[i].c);
      if (tbl[i].chk) begin
        d = tbl[i].d;
        chk("tbl_valid", d, longint'(g_vld[d]), 1);
        chk("tbl_dout", d, g_dout[d], tbl[i].e_dout);
        chk("tbl_ch", d, longint'(g_ch[d]), longint'(tbl[i].e_ch));
        chk("tbl_ovf", d, longint'(g_ovf[d]), longint'(tbl[i].e_ovf));
      end
    end

    // asynchronous reset mid-frame, while a strobe is high
    step(16'sh0300, 1, 0, 0);
    step(16'sh0500, 1, 1, 0);
    din_valid = 1'b0; din_last = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_valid", k, longint'(g_vld[k]), 0);
      chk("rst_dout", k, g_dout[k], 0);
      chk("rst_ch", k, longint'(g_ch[k]), 0);
      chk("rst_ovf", k, longint'(g_ovf[k]), 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step(16'sh0100, 1, 1, 0);
    step(16'sh0200, 1, 1, 0);

    // randomized stream against the model
    for (int i = 0; i < 500; i++)
      step(16'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    step(16'sh0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
